// File: rtl/tri_bbox_scanner_pkg.sv
// rtl/tri_bbox_scanner_pkg.sv - shared graphics types and helpers for the bounding-box scanner
package tri_bbox_scanner_pkg;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } int_vertex;

  typedef struct packed {
    int_vertex a;
    int_vertex b;
    int_vertex c;
  } int_triangle;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    SCAN = 2'd2
  } scan_state_t;

  function automatic logic signed [31:0] min3(input logic signed [31:0] p,
                                              input logic signed [31:0] q,
                                              input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic logic signed [31:0] max3(input logic signed [31:0] p,
                                              input logic signed [31:0] q,
                                              input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

endpackage

// File: rtl/tri_bbox_clip.sv
// rtl/tri_bbox_clip.sv - combinational triangle bounding box clamped to the display
module tri_bbox_clip
  import tri_bbox_scanner_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 100,
  parameter int DISPLAY_HEIGHT = 100
) (
  input  int_triangle        tri_in,
  output logic signed [31:0] min_x,
  output logic signed [31:0] max_x,
  output logic signed [31:0] min_y,
  output logic signed [31:0] max_y
);

  localparam logic signed [31:0] X_LIM = DISPLAY_WIDTH - 1;
  localparam logic signed [31:0] Y_LIM = DISPLAY_HEIGHT - 1;

  logic signed [31:0] lo_x, hi_x, lo_y, hi_y;

  always_comb begin
    lo_x  = min3(tri_in.a.x, tri_in.b.x, tri_in.c.x);
    hi_x  = max3(tri_in.a.x, tri_in.b.x, tri_in.c.x);
    lo_y  = min3(tri_in.a.y, tri_in.b.y, tri_in.c.y);
    hi_y  = max3(tri_in.a.y, tri_in.b.y, tri_in.c.y);
    min_x = (lo_x < 32'sd0) ? 32'sd0 : lo_x;
    max_x = (hi_x > X_LIM) ? X_LIM : hi_x;
    min_y = (lo_y < 32'sd0) ? 32'sd0 : lo_y;
    max_y = (hi_y > Y_LIM) ? Y_LIM : hi_y;
  end

endmodule

// File: rtl/tri_bbox_scanner.sv
// rtl/tri_bbox_scanner.sv - walks a triangle's clipped bounding box, LANES pixels per beat
module tri_bbox_scanner
  import tri_bbox_scanner_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 100,
  parameter int DISPLAY_HEIGHT = 100,
  parameter int COORD_W        = 16,
  parameter int LANES          = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  int_triangle        in_tri,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [LANES-1:0]   pix_mask,
  output logic               pix_last,
  output logic               tri_empty
);

  scan_state_t        state;
  int_triangle        tri_q;
  logic signed [31:0] c_min_x, c_max_x, c_min_y, c_max_y;
  logic signed [31:0] box_min_x, box_max_x, box_max_y;
  logic signed [31:0] cur_x, cur_y, nxt_x, nxt_y;
  logic               box_ok, scan_done;

  tri_bbox_clip #(
    .DISPLAY_WIDTH (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT(DISPLAY_HEIGHT)
  ) u_clip (
    .tri_in(tri_q),
    .min_x (c_min_x),
    .max_x (c_max_x),
    .min_y (c_min_y),
    .max_y (c_max_y)
  );

  function automatic logic [LANES-1:0] lane_mask(input logic signed [31:0] x,
                                                 input logic signed [31:0] hi);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (x + i <= hi);
    return m;
  endfunction

  function automatic logic last_beat(input logic signed [31:0] x, input logic signed [31:0] y,
                                     input logic signed [31:0] hx, input logic signed [31:0] hy);
    return (x + LANES > hx) && (y == hy);
  endfunction

  assign box_ok = (c_min_x <= c_max_x) && (c_min_y <= c_max_y);
  assign pix_x  = cur_x[COORD_W-1:0];
  assign pix_y  = cur_y[COORD_W-1:0];

  // Raster step: advance along the row, wrap to the next row, or finish.
  always_comb begin
    nxt_x     = cur_x;
    nxt_y     = cur_y;
    scan_done = 1'b0;
    if (cur_x + LANES <= box_max_x) begin
      nxt_x = cur_x + LANES;
    end else if (cur_y < box_max_y) begin
      nxt_x = box_min_x;
      nxt_y = cur_y + 32'sd1;
    end else begin
      scan_done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tri_ready <= 1'b1;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      pix_mask  <= '0;
      tri_empty <= 1'b0;
      tri_q     <= '0;
      box_min_x <= '0;
      box_max_x <= '0;
      box_max_y <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
    end else begin
      tri_empty <= 1'b0;
      case (state)
        IDLE: begin
          if (tri_valid) begin
            tri_q     <= in_tri;
            tri_ready <= 1'b0;
            state     <= CLIP;
          end
        end
        CLIP: begin
          box_min_x <= c_min_x;
          box_max_x <= c_max_x;
          box_max_y <= c_max_y;
          if (box_ok) begin
            state     <= SCAN;
            cur_x     <= c_min_x;
            cur_y     <= c_min_y;
            pix_valid <= 1'b1;
            pix_mask  <= lane_mask(c_min_x, c_max_x);
            pix_last  <= last_beat(c_min_x, c_min_y, c_max_x, c_max_y);
          end else begin
            state     <= IDLE;
            tri_ready <= 1'b1;
            tri_empty <= 1'b1;
          end
        end
        SCAN: begin
          if (pix_ready) begin
            if (scan_done) begin
              state     <= IDLE;
              tri_ready <= 1'b1;
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              pix_mask  <= '0;
            end else begin
              cur_x    <= nxt_x;
              cur_y    <= nxt_y;
              pix_mask <= lane_mask(nxt_x, box_max_x);
              pix_last <= last_beat(nxt_x, nxt_y, box_max_x, box_max_y);
            end
          end
        end
        default: begin
          state     <= IDLE;
          tri_ready <= 1'b1;
          pix_valid <= 1'b0;
          pix_last  <= 1'b0;
          pix_mask  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// tb/tb_tri_bbox_scanner.sv - directed self-checking bench for tri_bbox_scanner
module tb_tri_bbox_scanner;
  import tri_bbox_scanner_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        tri_valid, tri_valid1;
  logic        tri_ready, tri_ready1;
  int_triangle in_tri;
  logic        pix_valid, pix_valid1;
  logic        pix_ready, pix_ready1;
  logic [15:0] pix_x, pix_y, pix_x1, pix_y1;
  logic [3:0]  pix_mask;
  logic [0:0]  pix_mask1;
  logic        pix_last, pix_last1;
  logic        tri_empty, tri_empty1;

  int checks = 0;
  int errors = 0;

  logic [15:0] ex_x[8];
  logic [15:0] ex_y[8];
  logic [3:0]  ex_m[8];
  logic        ex_l[8];

  tri_bbox_scanner #(.DISPLAY_WIDTH(100), .DISPLAY_HEIGHT(100), .COORD_W(16), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready), .in_tri(in_tri),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_mask(pix_mask), .pix_last(pix_last), .tri_empty(tri_empty)
  );

  tri_bbox_scanner #(.DISPLAY_WIDTH(100), .DISPLAY_HEIGHT(100), .COORD_W(16), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid1), .tri_ready(tri_ready1), .in_tri(in_tri),
    .pix_valid(pix_valid1), .pix_ready(pix_ready1), .pix_x(pix_x1), .pix_y(pix_y1),
    .pix_mask(pix_mask1), .pix_last(pix_last1), .tri_empty(tri_empty1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int i, input int x, input int y, input logic [3:0] m, input logic l);
    ex_x[i] = x[15:0];
    ex_y[i] = y[15:0];
    ex_m[i] = m;
    ex_l[i] = l;
  endtask

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input bit both);
    int n = 0;
    while (!tri_ready && n < 50) begin
      step();
      n++;
    end
    check("tri_ready_before_send", tri_ready, 1);
    in_tri.a.x = ax; in_tri.a.y = ay;
    in_tri.b.x = bx; in_tri.b.y = by;
    in_tri.c.x = cx; in_tri.c.y = cy;
    tri_valid  = 1'b1;
    tri_valid1 = both;
    step();
    tri_valid  = 1'b0;
    tri_valid1 = 1'b0;
    check("accepted", tri_ready, 0);
    check("no_beat_in_clip", pix_valid, 0);
  endtask

  // Called one cycle after acceptance+1 (first beat visible); consumes n_exp beats.
  task automatic run_beats(input int n_exp, input bit rnd);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [36:0] hold = '0;
    while (got < n_exp && cyc < 200) begin
      if (pix_valid) begin
        if (stalled) check("stall_stable", {pix_x, pix_y, pix_mask, pix_last}, hold);
        pix_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (pix_ready) begin
          check($sformatf("beat%0d_x", got), pix_x, ex_x[got]);
          check($sformatf("beat%0d_y", got), pix_y, ex_y[got]);
          check($sformatf("beat%0d_mask", got), pix_mask, ex_m[got]);
          check($sformatf("beat%0d_last", got), pix_last, ex_l[got]);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold = {pix_x, pix_y, pix_mask, pix_last};
        end
      end else begin
        pix_ready = 1'b0;
      end
      step();
      cyc++;
    end
    pix_ready = 1'b0;
    check("beat_count", got, n_exp);
    check("idle_after_last_valid", pix_valid, 0);
    check("idle_after_last_ready", tri_ready, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    tri_valid  = 1'b0;
    tri_valid1 = 1'b0;
    pix_ready  = 1'b0;
    pix_ready1 = 1'b1;
    in_tri     = '0;
    repeat (3) step();
    check("rst_tri_ready", tri_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_tri_empty", tri_empty, 0);
    check("rst_pix_xy", {pix_x, pix_y}, 0);
    check("rst_pix_mask", pix_mask, 0);
    rst_n = 1'b1;
    step();

    // Two-row box 10..15 x 10..11, full ready
    set_exp(0, 10, 10, 4'b1111, 0);
    set_exp(1, 14, 10, 4'b0011, 0);
    set_exp(2, 10, 11, 4'b1111, 0);
    set_exp(3, 14, 11, 4'b0011, 1);
    send_tri(10, 10, 15, 10, 10, 11, 0);
    step();
    check("first_beat_latency", pix_valid, 1);
    run_beats(4, 0);

    // Negative coordinates clamp to 0..3 x 0..2
    set_exp(0, 0, 0, 4'b1111, 0);
    set_exp(1, 0, 1, 4'b1111, 0);
    set_exp(2, 0, 2, 4'b1111, 1);
    send_tri(-5, -5, 3, -5, -5, 2, 0);
    step();
    check("neg_first_valid", pix_valid, 1);
    run_beats(3, 0);

    // Fully off-screen: empty pulse, no beats
    send_tri(150, 150, 200, 150, 150, -20, 0);
    check("empty_not_yet", tri_empty, 0);
    step();
    check("empty_pulse", tri_empty, 1);
    check("empty_ready", tri_ready, 1);
    check("empty_no_beat", pix_valid, 0);
    step();
    check("empty_pulse_ends", tri_empty, 0);
    check("empty_still_no_beat", pix_valid, 0);

    // Single corner pixel on both lane counts
    set_exp(0, 99, 99, 4'b0001, 1);
    send_tri(99, 99, 99, 99, 99, 99, 1);
    step();
    check("corner_valid", pix_valid, 1);
    check("l1_corner_valid", pix_valid1, 1);
    check("l1_corner_xy", {pix_x1, pix_y1}, {16'd99, 16'd99});
    check("l1_corner_mask", pix_mask1, 1);
    check("l1_corner_last", pix_last1, 1);
    run_beats(1, 0);
    check("l1_done", pix_valid1, 0);

    // Permuted vertex order with random back-pressure gives the same sequence
    set_exp(0, 10, 10, 4'b1111, 0);
    set_exp(1, 14, 10, 4'b0011, 0);
    set_exp(2, 10, 11, 4'b1111, 0);
    set_exp(3, 14, 11, 4'b0011, 1);
    send_tri(10, 11, 15, 10, 10, 10, 0);
    step();
    run_beats(4, 1);

    // Reset during the second beat abandons the triangle
    send_tri(10, 10, 15, 10, 10, 11, 0);
    step();
    check("rst_case_beat0_x", pix_x, 10);
    pix_ready = 1'b1;
    step();
    pix_ready = 1'b0;
    check("rst_case_beat1_x", pix_x, 14);
    check("rst_case_beat1_valid", pix_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", pix_valid, 0);
    check("async_rst_ready", tri_ready, 1);
    check("async_rst_mask", pix_mask, 0);
    repeat (2) step();
    rst_n = 1'b1;
    pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_beats_after_rst", pix_valid, 0);
    end
    pix_ready = 1'b0;
    set_exp(0, 0, 0, 4'b0001, 1);
    send_tri(0, 0, 0, 0, 0, 0, 0);
    step();
    run_beats(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_bbox_scanner.md
TRI_BBOX_SCANNER -- requirements
Module: tri_bbox_scanner

Interface
REQ-001 Parameter DISPLAY_WIDTH, default 100, meaning display columns; valid x range 0..DISPLAY_WIDTH-1.
REQ-002 Parameter DISPLAY_HEIGHT, default 100, meaning display rows; valid y range 0..DISPLAY_HEIGHT-1.
REQ-003 Parameter COORD_W, default 16, meaning output coordinate width; SHALL hold DISPLAY_WIDTH-1 and DISPLAY_HEIGHT-1.
REQ-004 Parameter LANES, default 1, legal 1..8, meaning adjacent x pixels emitted per beat.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 tri_valid  in  1  in_tri valid.
REQ-009 tri_ready  out  1  block can accept a triangle.
REQ-010 in_tri  in  int_triangle  vertices a, b, c, each with signed 32-bit x, y.
REQ-011 pix_valid  out  1  pixel beat valid.
REQ-012 pix_ready  in  1  downstream accepts beat.
REQ-013 pix_x, pix_y  out  COORD_W each  x of lane 0, row y.
REQ-014 pix_mask  out  LANES  bit i set = pixel (pix_x+i, pix_y) inside box.
REQ-015 pix_last  out  1  final beat of current triangle.
REQ-016 tri_empty  out  1  one-cycle pulse: accepted triangle had no on-screen box.

Function
REQ-017 FSM states SHALL be IDLE, CLIP, SCAN; tri_ready=1 only in IDLE.
REQ-018 IDLE -> CLIP on tri_valid&&tri_ready; in_tri SHALL be registered on that edge.
REQ-019 CLIP SHALL compute min_x=max(0,min(ax,bx,cx)), max_x=min(DISPLAY_WIDTH-1,max(ax,bx,cx)), likewise y with DISPLAY_HEIGHT-1, in signed 32-bit, and register them.
REQ-020 CLIP -> SCAN with cur_x=min_x, cur_y=min_y if min_x<=max_x and min_y<=max_y; otherwise CLIP -> IDLE with tri_empty=1 for that one cycle and no beat.
REQ-021 First pix_valid SHALL assert exactly 2 cycles after triangle acceptance.
REQ-022 In SCAN pix_valid=1, pix_x=cur_x, pix_y=cur_y, pix_mask[i]=(cur_x+i<=max_x).
REQ-023 On pix_valid&&!pix_ready, all pix_* outputs SHALL hold stable.
REQ-024 On pix_valid&&pix_ready: if cur_x+LANES<=max_x then cur_x+=LANES; else if cur_y<max_y then cur_x=min_x, cur_y+=1; else SCAN -> IDLE.
REQ-025 pix_last=1 iff cur_x+LANES>max_x and cur_y==max_y.
REQ-026 With pix_ready held high, one beat per cycle; beats per triangle = ceil((max_x-min_x+1)/LANES)*(max_y-min_y+1).
REQ-027 The cycle after the last handshake SHALL be IDLE with tri_ready=1; no overlap of triangles.
REQ-028 Degenerate box (one pixel) SHALL produce one beat, mask lane 0 only, pix_last=1.
REQ-029 Vertex order and winding SHALL not affect output.

Reset
REQ-030 Reset assertion SHALL immediately force IDLE, tri_ready=1, pix_valid=0, pix_last=0, tri_empty=0, pix_x=pix_y=0, pix_mask=0, box and in_tri registers 0.
REQ-031 Reset mid-SCAN SHALL abandon the triangle; no further beats after release until a new triangle is accepted.

Structure
REQ-032 int_vertex/int_triangle typedefs and the FSM state enum SHALL live in the shared graphics package.
REQ-033 Clamp/box arithmetic SHALL be a combinational sub-module tri_bbox_clip, instanced once, outputs registered in CLIP.

Verification (DISPLAY 100x100, LANES=4 unless noted)
REQ-034 Tri (10,10),(15,10),(10,11) -> 4 beats (10,10,1111),(14,10,0011),(10,11,1111),(14,11,0011); pix_last on 4th only.
REQ-035 Tri (-5,-5),(3,-5),(-5,2) -> box 0..3 x 0..2; 3 beats x=0 mask 1111, y=0,1,2.
REQ-036 Tri (150,150),(200,150),(150,-20) -> tri_empty pulse 2 cycles after accept, zero beats, tri_ready=1 next cycle.
REQ-037 Tri (99,99)x3 -> single beat (99,99) mask 0001 pix_last=1; LANES=1 same tri -> mask 1.
REQ-038 REQ-034 triangle with pix_ready random 50% -> identical beat sequence, outputs stable while stalled, no drops/duplicates.
REQ-039 Assert rst_n low during 2nd beat of REQ-034 -> pix_valid=0 same cycle; after release, new tri (0,0)x3 -> single beat (0,0).
